// File: rtl/multdiv_seq_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multdiv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef logic [5:0] cnt_t;

    localparam cnt_t        MULT_ITERS = 6'd16;
    localparam cnt_t        DIV_ITERS  = 6'd32;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    // Two's-complement negate when n is set; used for magnitudes and quotient sign.
    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv_seq_if.sv
// Operand/strobe/result bundle between decode/writeback and the mul/div unit.
// Latency: n/a (wiring only).
// Backpressure: none; the pipeline stalls until data_resultRDY pulses.
interface multdiv_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_seq_booth_recode_4.sv
// Radix-4 Booth recoder: 3-bit multiplier window to {0, +-M, +-2M} selects.
// Latency: combinational.
// Backpressure: n/a.
module booth_recode_4 (
    input  logic [2:0] window,
    output logic       zero,
    output logic       negate,
    output logic       dbl
);

    // 000 / 111 contribute nothing; the top bit gives the sign; 011 / 100 are the 2M cases.
    always_comb begin
        zero   = (window == 3'b000) || (window == 3'b111);
        negate = window[2] && !zero;
        dbl    = (window == 3'b011) || (window == 3'b100);
    end

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed 32-bit multiply (radix-4 Booth) and divide (restoring on magnitudes).
// Latency: RDY pulse 17 cycles after a multiply strobe, 33 cycles after a divide strobe.
// Backpressure: none; a new strobe aborts any operation in flight and restarts.
module multdiv_seq
    import multdiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    multdiv_seq_if.slave   bus
);

    if (WIDTH != 32) begin : g_width_chk
        $error("multdiv_seq: only WIDTH=32 is supported");
    end

    state_t state_q, state_d;
    cnt_t   cnt_q;
    logic   start_mult, start_div;
    logic   mult_step, div_step;
    logic   mult_finish, div_finish;

    // Multiply datapath state
    logic [WIDTH-1:0] mcand_q;
    logic [33:0]      acc_q;
    logic [WIDTH-1:0] mq_q;
    logic             qm1_q;

    // Divide datapath state
    logic [32:0]      rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             dz_q, ovf_q, qneg_q;

    // Result registers
    logic [WIDTH-1:0] result_q;
    logic             exc_q;

    logic        b_zero, b_negate, b_dbl;
    logic [33:0] m_ext, m_mag, addend, booth_sum;
    logic [33:0] trial;
    logic        mult_ovf;

    booth_recode_4 u_booth (
        .window (mq_q[1:0] == 2'b00 && !qm1_q ? 3'b000 : {mq_q[1:0], qm1_q}),
        .zero   (b_zero),
        .negate (b_negate),
        .dbl    (b_dbl)
    );

    assign m_ext     = {{2{mcand_q[31]}}, mcand_q};
    assign m_mag     = b_dbl ? {m_ext[32:0], 1'b0} : m_ext;
    assign addend    = b_zero ? 34'd0 : (b_negate ? -m_mag : m_mag);
    assign booth_sum = acc_q + addend;

    // Product bits 63..31 plus the accumulator's sign-extension bits must all agree.
    assign mult_ovf  = !(({acc_q, mq_q[31]} == '0) || ({acc_q, mq_q[31]} == '1));

    // Trial subtract of the divisor from the shifted partial remainder; MSB set means negative.
    assign trial     = {rem_q, quo_q[31]} - {2'b00, dvsr_q};

    // Next-state and control decode; a strobe in any state restarts, MULT wins over DIV.
    always_comb begin
        state_d    = state_q;
        start_mult = 1'b0;
        start_div  = 1'b0;
        if (bus.ctrl_MULT) begin
            state_d    = ST_MULT;
            start_mult = 1'b1;
        end else if (bus.ctrl_DIV) begin
            state_d   = ST_DIV;
            start_div = 1'b1;
        end else begin
            case (state_q)
                ST_MULT: if (cnt_q == MULT_ITERS) state_d = ST_DONE;
                ST_DIV:  if (cnt_q == DIV_ITERS)  state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        mult_step   = !start_mult && !start_div && (state_q == ST_MULT) && (cnt_q < MULT_ITERS);
        div_step    = !start_mult && !start_div && (state_q == ST_DIV)  && (cnt_q < DIV_ITERS);
        mult_finish = (state_q == ST_MULT) && (state_d == ST_DONE);
        div_finish  = (state_q == ST_DIV)  && (state_d == ST_DONE);
    end

    // State register and iteration counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_mult || start_div)  cnt_q <= '0;
            else if (mult_step || div_step) cnt_q <= cnt_q + 6'd1;
        end
    end

    // Booth accumulator: add the recoded partial product, then shift {acc, mq, qm1} right by 2.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
        end else if (start_mult) begin
            mcand_q <= bus.data_operandA;
            acc_q   <= '0;
            mq_q    <= bus.data_operandB;
            qm1_q   <= 1'b0;
        end else if (mult_step) begin
            acc_q <= {{2{booth_sum[33]}}, booth_sum[33:2]};
            mq_q  <= {booth_sum[1:0], mq_q[31:2]};
            qm1_q <= mq_q[1];
        end
    end

    // Restoring divider on magnitudes; special cases are captured at start and applied at the end.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            qneg_q <= 1'b0;
        end else if (start_div) begin
            rem_q  <= '0;
            quo_q  <= neg_if(bus.data_operandA[31], bus.data_operandA);
            dvsr_q <= neg_if(bus.data_operandB[31], bus.data_operandB);
            dz_q   <= (bus.data_operandB == '0);
            ovf_q  <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
            qneg_q <= bus.data_operandA[31] ^ bus.data_operandB[31];
        end else if (div_step) begin
            rem_q <= trial[33] ? {rem_q[31:0], quo_q[31]} : trial[32:0];
            quo_q <= {quo_q[30:0], !trial[33]};
        end
    end

    // Result and exception change only on the way into DONE and hold otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (mult_finish) begin
            result_q <= mq_q;
            exc_q    <= mult_ovf;
        end else if (div_finish) begin
            result_q <= dz_q ? '0 : neg_if(qneg_q, quo_q);
            exc_q    <= dz_q || ovf_q;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == ST_DONE);

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed + randomized bench for multdiv_seq with a plain-arithmetic reference model.
// Latency: checks RDY lands exactly 17 / 33 edges after a strobe.
// Backpressure: n/a.
module tb_multdiv_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] prev_res = 32'd0;
    logic        prev_exc = 1'b0;

    multdiv_seq_if bus ();

    multdiv_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic, SV division truncates toward zero.
    function automatic void model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        if (mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(r)));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            p = longint'($signed(a)) / longint'($signed(b));
            r = p[31:0];
            e = 1'b0;
        end
    endfunction

    // Called #1 after a posedge. Issues the strobe(s), then checks latency, hold, result, pulse width.
    task automatic do_op(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [31:0] er;
        logic        ee;
        int          lat;
        int          exp_lat;
        model(mul, a, b, er, ee);
        exp_lat = mul ? 17 : 33;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = dv;
        @(posedge clock); #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge clock); #1;
            if (i == 5) chk({tag, ".hold"}, bus.data_result, prev_res);
            if (bus.data_resultRDY) lat = i;
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".res"}, bus.data_result, er);
        chk({tag, ".exc"}, {31'd0, bus.data_exception}, {31'd0, ee});
        @(posedge clock); #1;
        chk({tag, ".rdy1"}, {31'd0, bus.data_resultRDY}, 32'd0);
        chk({tag, ".after"}, bus.data_result, er);
        prev_res = er;
        prev_exc = ee;
    endtask

    initial begin
        int rdy_cnt;
        logic [31:0] a, b;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset.rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        chk("reset.res", bus.data_result, 32'd0);
        chk("reset.exc", {31'd0, bus.data_exception}, 32'd0);

        do_op(1, 0, 32'd7,         32'hFFFF_FFFD, "mul_7_m3");
        repeat (4) @(posedge clock);
        #1;
        chk("hold.idle", bus.data_result, 32'hFFFF_FFEB);
        do_op(1, 0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
        do_op(1, 0, 32'h8000_0000, 32'd1,         "mul_min_1");
        do_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_m1_m1");
        do_op(1, 0, 32'h8000_0000, 32'h8000_0000, "mul_min_min");
        do_op(0, 1, 32'hFFFF_FFF9, 32'd2,         "div_m7_2");
        do_op(0, 1, 32'd100,       32'd7,         "div_100_7");
        do_op(0, 1, 32'd100,       32'd0,         "div_by0");
        do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(0, 1, 32'h8000_0000, 32'd3,         "div_min_3");

        // Reset during a multiply: no pulse ever, outputs cleared.
        bus.data_operandA = 32'd11;
        bus.data_operandB = 32'd13;
        bus.ctrl_MULT     = 1'b1;
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b0;
        rdy_cnt = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (bus.data_resultRDY) rdy_cnt++;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus.data_resultRDY) rdy_cnt++;
        end
        chk("rst_mid.rdy_cnt", rdy_cnt, 0);
        chk("rst_mid.res", bus.data_result, 32'd0);
        chk("rst_mid.exc", {31'd0, bus.data_exception}, 32'd0);
        prev_res = 32'd0;
        do_op(0, 1, 32'd9, 32'd3, "div_9_3");

        // Abort: MULT 5*5, then DIV 20/4 at iteration 8; only the divide reports.
        bus.data_operandA = 32'd5;
        bus.data_operandB = 32'd5;
        bus.ctrl_MULT     = 1'b1;
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b0;
        rdy_cnt = 0;
        repeat (7) begin
            @(posedge clock); #1;
            if (bus.data_resultRDY) rdy_cnt++;
        end
        chk("abort.early_rdy", rdy_cnt, 0);
        do_op(0, 1, 32'd20, 32'd4, "abort_div");
        do_op(1, 1, 32'd3,  32'd4, "both_strobes");

        // Randomized operations with occasional corner operands.
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = $urandom_range(0, 3);
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            if (n % 2 == 0) do_op(1, 0, a, b, $sformatf("rnd_mul%0d", n));
            else            do_op(0, 1, a, b, $sformatf("rnd_div%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
